// File: rtl/mux_pkg.sv
// Shared constants, scan-state encoding and the masked wrap-around channel search
// used by the N:1 scanning multiplexer.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Upper bound on channel count; the search function works on this fixed width.
  localparam int MAX_CH = 16;
  localparam int IDX_W  = 4;

  typedef enum logic {
    IDLE,
    DWELL
  } scan_state_t;

  // First unmasked channel strictly after cur (with wrap over nch channels).
  // Returns cur unchanged when every channel is masked.
  function automatic logic [IDX_W-1:0] next_ch(
    input logic [IDX_W-1:0]  cur,
    input logic [MAX_CH-1:0] mask,
    input logic [IDX_W:0]    nch
  );
    logic [IDX_W-1:0] res;
    logic             found;
    logic [IDX_W:0]   idx;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= MAX_CH; k++) begin
      if ((IDX_W+1)'(k) <= nch) begin
        idx = {1'b0, cur} + (IDX_W+1)'(k);
        if (idx >= nch) begin
          idx = idx - nch;
        end
        if (!found && !mask[idx[IDX_W-1:0]]) begin
          res   = idx[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Scan controller: owns the current channel and the dwell counter, and skips
// masked channels when advancing.
module mux_scan_ctr
  import mux_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int SEL_W   = $clog2(NUM_CH),
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_scan,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [NUM_CH-1:0]  i_mask,
  output logic [SEL_W-1:0]   o_cur,
  output logic               o_cur_ok
);

  localparam logic [IDX_W:0] NCH_L = (IDX_W+1)'(NUM_CH);

  scan_state_t        r_state;
  logic [SEL_W-1:0]   r_cur;
  logic [DWELL_W-1:0] r_dcnt;

  logic [MAX_CH-1:0]  w_mask_ext;
  logic               w_all_masked;
  logic [SEL_W-1:0]   w_first;
  logic [SEL_W-1:0]   w_cur;
  logic [SEL_W-1:0]   w_next;
  logic               w_cur_masked;
  logic               w_adv;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_CH; gi++) begin : g_mask
      if (gi < NUM_CH) begin : g_real
        assign w_mask_ext[gi] = i_mask[gi];
      end else begin : g_fill
        assign w_mask_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_all_masked = &i_mask;
  // Searching after the last channel yields the lowest unmasked one.
  assign w_first      = SEL_W'(next_ch(IDX_W'(NUM_CH - 1), w_mask_ext, NCH_L));
  assign w_cur        = (r_state == IDLE && !w_all_masked) ? w_first : r_cur;
  assign w_cur_masked = w_mask_ext[IDX_W'(w_cur)];
  assign w_next       = SEL_W'(next_ch(IDX_W'(w_cur), w_mask_ext, NCH_L));
  // >= so that shrinking dwell below the running count advances at once;
  // a channel masked mid-dwell is left immediately.
  assign w_adv        = w_cur_masked || (r_dcnt >= i_dwell);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_dcnt  <= '0;
    end else if (i_en) begin
      if (!i_scan) begin
        r_state <= IDLE;
        r_cur   <= '0;
        r_dcnt  <= '0;
      end else begin
        r_state <= DWELL;
        if (w_all_masked) begin
          r_cur  <= r_cur;
          r_dcnt <= '0;
        end else if (w_adv) begin
          r_cur  <= w_next;
          r_dcnt <= '0;
        end else begin
          r_cur  <= w_cur;
          r_dcnt <= r_dcnt + DWELL_W'(1);
        end
      end
    end
  end

  assign o_cur    = w_cur;
  assign o_cur_ok = !w_all_masked && !w_cur_masked;

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N:1 multiplexer with MANUAL select and SCAN (auto-walk) modes.
// Optional channel masking is enabled by defining MUX_CH_MASK_EN.
module mux_nto1_scan
  import mux_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_CH  = 4,
  parameter int SEL_W   = $clog2(NUM_CH),
  parameter int DWELL_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
`ifdef MUX_CH_MASK_EN
  input  logic [NUM_CH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]        out,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  output logic                    sel_err
);

  localparam int             NPAD  = 1 << SEL_W;
  localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(NUM_CH);

  logic [WIDTH-1:0]  w_ch [NPAD];
  logic [NPAD-1:0]   w_mask_pad;
  logic [NUM_CH-1:0] w_mask;
  logic              w_sel_ok;
  logic [SEL_W-1:0]  w_cur;
  logic              w_cur_ok;

  logic [WIDTH-1:0]  r_out;
  logic [SEL_W-1:0]  r_out_ch;
  logic              r_out_valid;
  logic              r_sel_err;

`ifdef MUX_CH_MASK_EN
  assign w_mask = ch_mask;
`else
  assign w_mask = '0;
`endif

  // Pad the channel array to a power of two so any sel value indexes safely.
  genvar gi;
  generate
    for (gi = 0; gi < NPAD; gi++) begin : g_pad
      if (gi < NUM_CH) begin : g_real
        assign w_ch[gi]       = in_data[gi*WIDTH +: WIDTH];
        assign w_mask_pad[gi] = w_mask[gi];
      end else begin : g_fill
        assign w_ch[gi]       = '0;
        assign w_mask_pad[gi] = 1'b1;
      end
    end
  endgenerate

  assign w_sel_ok = ({1'b0, sel} < NCH_L) && !w_mask_pad[sel];

  mux_scan_ctr #(
    .NUM_CH  (NUM_CH),
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_scan_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (en),
    .i_scan   (mode == MODE_SCAN),
    .i_dwell  (dwell),
    .i_mask   (w_mask),
    .o_cur    (w_cur),
    .o_cur_ok (w_cur_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else if (en) begin
      if (mode == MODE_MANUAL) begin
        if (w_sel_ok) begin
          r_out       <= w_ch[sel];
          r_out_ch    <= sel;
          r_out_valid <= 1'b1;
          r_sel_err   <= 1'b0;
        end else begin
          r_out       <= '0;
          r_out_ch    <= '0;
          r_out_valid <= 1'b0;
          r_sel_err   <= 1'b1;
        end
      end else begin
        r_sel_err <= 1'b0;
        if (w_cur_ok) begin
          r_out       <= w_ch[w_cur];
          r_out_ch    <= w_cur;
          r_out_valid <= 1'b1;
        end else begin
          r_out       <= '0;
          r_out_ch    <= '0;
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out       = r_out;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: a 4-channel and a 5-channel instance share stimulus
// and are checked every cycle against a channel-walk reference model.
module tb_mux_nto1_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic       mode;
  logic [3:0] dwell;
  logic [2:0] sel_v;
  logic [4:0] mask_v;
  logic [7:0] data [5];

  logic [31:0] in4;
  logic [39:0] in5;
  logic [1:0]  sel4;
  logic [2:0]  sel5;
  assign in4  = {data[3], data[2], data[1], data[0]};
  assign in5  = {data[4], data[3], data[2], data[1], data[0]};
  assign sel4 = sel_v[1:0];
  assign sel5 = sel_v;

  logic [7:0] out4, out5;
  logic [1:0] ch4;
  logic [2:0] ch5;
  logic       v4, v5, e4, e5;

`ifdef MUX_CH_MASK_EN
  logic [3:0] mask4;
  assign mask4 = mask_v[3:0];
`endif

  mux_nto1_scan #(.WIDTH(8), .NUM_CH(4), .DWELL_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel4), .dwell(dwell),
    .in_data(in4),
`ifdef MUX_CH_MASK_EN
    .ch_mask(mask4),
`endif
    .out(out4), .out_ch(ch4), .out_valid(v4), .sel_err(e4)
  );

  mux_nto1_scan #(.WIDTH(8), .NUM_CH(5), .DWELL_W(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel5), .dwell(dwell),
    .in_data(in5),
`ifdef MUX_CH_MASK_EN
    .ch_mask(mask_v),
`endif
    .out(out5), .out_ch(ch5), .out_valid(v5), .sel_err(e5)
  );

  // Reference model: index 0 = 4-channel instance, 1 = 5-channel instance.
  bit         m_act [2];
  int         m_cur [2];
  int         m_cnt [2];
  logic [7:0] x_out [2];
  int         x_ch  [2];
  bit         x_v   [2];
  bit         x_e   [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  function automatic bit masked(input int k);
    return mask_v[k];
  endfunction

  function automatic int next_un(input int d, input int c);
    for (int k = 1; k <= nch(d); k++) begin
      if (!masked((c + k) % nch(d))) return (c + k) % nch(d);
    end
    return c;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_cur[d] = 0; m_cnt[d] = 0;
      x_out[d] = 0; x_ch[d] = 0; x_v[d] = 0; x_e[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int  n, s;
    bit  all_m;
    n = nch(d);
    s = (d == 0) ? int'(sel_v) % 4 : int'(sel_v);
    if (!en) return;
    if (mode == 1'b0) begin
      m_act[d] = 0; m_cur[d] = 0; m_cnt[d] = 0;
      if (s < n && !masked(s)) begin
        x_out[d] = data[s]; x_ch[d] = s; x_v[d] = 1; x_e[d] = 0;
      end else begin
        x_out[d] = 0; x_ch[d] = 0; x_v[d] = 0; x_e[d] = 1;
      end
    end else begin
      all_m = 1;
      for (int k = 0; k < n; k++) if (!masked(k)) all_m = 0;
      if (!m_act[d]) begin
        m_cur[d] = all_m ? 0 : next_un(d, n - 1);
        m_cnt[d] = 0;
      end
      m_act[d] = 1;
      x_e[d]   = 0;
      if (all_m) begin
        x_out[d] = 0; x_ch[d] = 0; x_v[d] = 0;
        m_cnt[d] = 0;
      end else if (masked(m_cur[d])) begin
        x_out[d] = 0; x_ch[d] = 0; x_v[d] = 0;
        m_cur[d] = next_un(d, m_cur[d]);
        m_cnt[d] = 0;
      end else begin
        x_out[d] = data[m_cur[d]]; x_ch[d] = m_cur[d]; x_v[d] = 1;
        if (m_cnt[d] >= int'(dwell)) begin
          m_cnt[d] = 0;
          m_cur[d] = next_un(d, m_cur[d]);
        end else begin
          m_cnt[d]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("out4",   out4, x_out[0]);
    check("ch4",    ch4,  x_ch[0]);
    check("valid4", v4,   x_v[0]);
    check("err4",   e4,   x_e[0]);
    check("out5",   out5, x_out[1]);
    check("ch5",    ch5,  x_ch[1]);
    check("valid5", v5,   x_v[1]);
    check("err5",   e5,   x_e[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare_all();
    $display("cyc %0d en=%0d mode=%0d sel=%0d dwell=%0d | d4 ch=%0d out=%h v=%0d e=%0d | d5 ch=%0d out=%h v=%0d e=%0d",
             cyc, en, mode, sel_v, dwell, ch4, out4, v4, e4, ch5, out5, v5, e5);
  endtask

  int exp_seq4 [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
  int exp_seq5 [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,4};
  int guard;

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 1'b0; dwell = 4'd0; sel_v = 3'd0; mask_v = 5'd0;
    for (int k = 0; k < 5; k++) data[k] = 8'($urandom);
    model_reset();

    // Asynchronous reset: outputs clear before any clock edge.
    #1 rst_n = 1'b0;
    #2 compare_all();
    tick();
    tick();
    rst_n = 1'b1;
    en = 1'b1;

    // MANUAL select and enable hold.
    data[0] = 8'hA0; data[1] = 8'hB1; data[2] = 8'hC2; data[3] = 8'hD3; data[4] = 8'hE4;
    sel_v = 3'd2;
    tick();
    check("man_out_c2", out4, 8'hC2);
    check("man_ch2", ch4, 2);
    check("man_valid", v4, 1);
    en = 1'b0; sel_v = 3'd1;
    for (int i = 0; i < 3; i++) tick();
    check("hold_out_c2", out4, 8'hC2);
    en = 1'b1;

    // Illegal select on the 5-channel instance.
    sel_v = 3'd6;
    tick();
    check("ill_err", e5, 1);
    check("ill_out", out5, 0);
    check("ill_valid", v5, 0);
    sel_v = 3'd4;
    tick();
    check("sel4_out", out5, 8'hE4);
    check("sel4_err", e5, 0);

    // SCAN with dwell=2 and wrap.
    mode = 1'b1; dwell = 4'd2;
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("scan4_%0d", i), ch4, exp_seq4[i]);
      check($sformatf("scan5_%0d", i), ch5, exp_seq5[i]);
    end
    guard = 0;
    while (ch4 !== 2'd2 && guard < 20) begin tick(); guard++; end
    check("wait_ch2", guard < 20, 1);
    mode = 1'b0; tick();
    mode = 1'b1; tick();
    check("restart_ch0", ch4, 0);

`ifdef MUX_CH_MASK_EN
    mode = 1'b0; tick();
    mask_v = 5'b00101; dwell = 4'd0; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mask_seq%0d", i), ch4, (i % 2 == 0) ? 1 : 3);
    end
    mask_v = 5'b11111;
    tick();
    check("allmask_valid", v4, 0);
    check("allmask_out", out4, 0);
    mask_v = 5'd0;
`endif

    // Dwell shrinks below the running count: advance immediately.
    mode = 1'b0; tick();
    mode = 1'b1; dwell = 4'd7;
    for (int i = 0; i < 5; i++) tick();
    dwell = 4'd1;
    tick();
    tick();
    check("dwell_shrink_ch1", ch4, 1);

    // Asynchronous reset mid-scan at channel 3.
    dwell = 4'd0;
    guard = 0;
    while (ch4 !== 2'd3 && guard < 10) begin tick(); guard++; end
    check("wait_ch3", guard < 10, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_mid_ch", ch4, 0);
    check("rst_mid_valid", v4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ch0", ch4, 0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) dwell = 4'($urandom_range(0, 3));
      sel_v = 3'($urandom);
      for (int k = 0; k < 5; k++) data[k] = 8'($urandom);
`ifdef MUX_CH_MASK_EN
      if ($urandom_range(0, 11) == 0) mask_v = 5'($urandom);
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
